// File: rtl/ser_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// idle line level and a counter-width helper.
package ser_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic SER_IDLE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } ser_state_e;

  // A counter over 0..n-1 needs at least one bit, even when n is 1.
  function automatic int ser_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_frame_tx_bit_tick_gen.sv
// Bit-period timer: pulses o_tick on the last clock of every DIV-cycle bit
// period while enabled, and holds its count at zero while disabled.
module bit_tick_gen
  import ser_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = ser_cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ser_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit 0, N data bits, stop bit 1,
// each bit held for DIV clocks, with a valid/ready input handshake.
module ser_frame_tx
  import ser_pkg::*;
#(
  parameter int N         = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_din,
  input  logic         i_din_valid,
  output logic         o_din_ready,
  output logic         o_sdo,
  output logic         o_busy,
  output logic         o_done
);

  localparam int BW = ser_cnt_width(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  ser_state_e r_state;
  logic [N-1:0]  r_sh;
  logic [BW-1:0] r_bit;
  logic          r_sdo;
  logic          r_busy;
  logic          r_ready;
  logic          r_done;

  ser_state_e    w_stateNext;
  logic [N-1:0]  w_shNext;
  logic [BW-1:0] w_bitNext;
  logic          w_sdoNext;
  logic          w_busyNext;
  logic          w_readyNext;
  logic          w_doneNext;

  logic          w_tick;
  logic          w_curBit;
  logic [N-1:0]  w_shifted;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state != S_IDLE),
    .o_tick (w_tick)
  );

  // The bit leaving the register next, and the register after it has left.
  assign w_curBit  = (MSB_FIRST != 0) ? r_sh[N-1] : r_sh[0];
  assign w_shifted = (MSB_FIRST != 0) ? {r_sh[N-2:0], 1'b0} : {1'b0, r_sh[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_sdo   <= SER_IDLE;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_sh    <= w_shNext;
      r_bit   <= w_bitNext;
      r_sdo   <= w_sdoNext;
      r_busy  <= w_busyNext;
      r_ready <= w_readyNext;
      r_done  <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_shNext    = r_sh;
    w_bitNext   = r_bit;
    w_sdoNext   = r_sdo;
    w_busyNext  = r_busy;
    w_readyNext = r_ready;
    w_doneNext  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_sdoNext   = SER_IDLE;
        w_busyNext  = 1'b0;
        w_readyNext = 1'b1;
        if (i_din_valid && r_ready) begin
          w_stateNext = S_START;
          w_shNext    = i_din;
          w_bitNext   = '0;
          w_sdoNext   = 1'b0;
          w_busyNext  = 1'b1;
          w_readyNext = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_stateNext = S_DATA;
          w_sdoNext   = w_curBit;
          w_shNext    = w_shifted;
          w_bitNext   = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == LAST_BIT) begin
            w_stateNext = S_STOP;
            w_sdoNext   = SER_IDLE;
          end else begin
            w_sdoNext = w_curBit;
            w_shNext  = w_shifted;
            w_bitNext = r_bit + BW'(1);
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_stateNext = S_IDLE;
          w_sdoNext   = SER_IDLE;
          w_busyNext  = 1'b0;
          w_readyNext = 1'b1;
          w_doneNext  = 1'b1;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign o_sdo       = r_sdo;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_din_ready = r_ready;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Directed self-checking bench for ser_frame_tx: an LSB-first DIV=4 instance
// and an MSB-first DIV=1 instance, checked against hand-computed frames.
module tb_ser_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din0, din1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       sdo0, sdo1;
  logic       busy0, busy1;
  logic       done0, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ser_frame_tx #(.N(8), .DIV(4), .MSB_FIRST(0)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .i_din       (din0),
    .i_din_valid (valid0),
    .o_din_ready (ready0),
    .o_sdo       (sdo0),
    .o_busy      (busy0),
    .o_done      (done0)
  );

  ser_frame_tx #(.N(8), .DIV(1), .MSB_FIRST(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .i_din       (din1),
    .i_din_valid (valid1),
    .o_din_ready (ready1),
    .o_sdo       (sdo1),
    .o_busy      (busy1),
    .o_done      (done1)
  );

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the handshake edge; walks the whole frame and
  // leaves the bench in the cycle that follows the completion edge.
  task automatic checkFrameBody(input int sel, input logic [9:0] expFrame,
                                input int div, input string tag);
    for (int c = 0; c < 10 * div; c++) begin
      checkOutput($sformatf("%s_c%0d_sdo", tag, c), (sel == 0) ? sdo0 : sdo1, expFrame[c / div]);
      checkOutput($sformatf("%s_c%0d_busy", tag, c), (sel == 0) ? busy0 : busy1, 1'b1);
      checkOutput($sformatf("%s_c%0d_done", tag, c), (sel == 0) ? done0 : done1, 1'b0);
      checkOutput($sformatf("%s_c%0d_ready", tag, c), (sel == 0) ? ready0 : ready1, 1'b0);
      applyStimulus();
    end
    checkOutput({tag, "_end_done"}, (sel == 0) ? done0 : done1, 1'b1);
    checkOutput({tag, "_end_busy"}, (sel == 0) ? busy0 : busy1, 1'b0);
    checkOutput({tag, "_end_ready"}, (sel == 0) ? ready0 : ready1, 1'b1);
    checkOutput({tag, "_end_sdo"}, (sel == 0) ? sdo0 : sdo1, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    din0   = 8'h00;
    din1   = 8'h00;
    valid0 = 1'b0;
    valid1 = 1'b0;

    // Reset values while reset is held
    #2;
    checkOutput("rst_sdo", sdo0, 1'b1);
    checkOutput("rst_busy", busy0, 1'b0);
    checkOutput("rst_done", done0, 1'b0);
    checkOutput("rst_ready", ready0, 1'b0);
    checkOutput("rst_ready1", ready1, 1'b0);
    applyStimulus();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rel_ready_before_edge", ready0, 1'b0);
    applyStimulus();
    checkOutput("rel_ready", ready0, 1'b1);
    checkOutput("rel_ready1", ready1, 1'b1);
    checkOutput("rel_sdo", sdo0, 1'b1);

    // LSB-first 8'hA5 at DIV=4
    din0   = 8'hA5;
    valid0 = 1'b1;
    applyStimulus();
    valid0 = 1'b0;
    checkFrameBody(0, 10'b1101001010, 4, "a5");
    applyStimulus();
    checkOutput("a5_done_one_cycle", done0, 1'b0);
    checkOutput("a5_idle_sdo", sdo0, 1'b1);

    // MSB-first 8'hC3 at DIV=1
    din1   = 8'hC3;
    valid1 = 1'b1;
    applyStimulus();
    valid1 = 1'b0;
    checkFrameBody(1, 10'b1110000110, 1, "c3");
    applyStimulus();
    checkOutput("c3_done_one_cycle", done1, 1'b0);

    // 8'h00 with din_valid held and din changed to 8'hFF mid-frame
    din0   = 8'h00;
    valid0 = 1'b1;
    applyStimulus();
    din0 = 8'hFF;
    checkFrameBody(0, 10'b1000000000, 4, "zero");
    valid0 = 1'b0;
    applyStimulus();
    checkOutput("zero_no_restart_busy", busy0, 1'b0);
    checkOutput("zero_no_restart_sdo", sdo0, 1'b1);

    // Back-to-back 8'h01 then 8'h80, valid held throughout
    din0   = 8'h01;
    valid0 = 1'b1;
    applyStimulus();
    din0 = 8'h80;
    checkFrameBody(0, 10'b1000000010, 4, "b2b1");
    applyStimulus();
    checkOutput("b2b_second_start_sdo", sdo0, 1'b0);
    checkOutput("b2b_second_start_busy", busy0, 1'b1);
    valid0 = 1'b0;
    checkFrameBody(0, 10'b1100000000, 4, "b2b2");
    applyStimulus();
    checkOutput("b2b_done_one_cycle", done0, 1'b0);

    // Reset during the third data bit of an all-zero frame
    din0   = 8'h00;
    valid0 = 1'b1;
    applyStimulus();
    valid0 = 1'b0;
    repeat (13) applyStimulus();
    checkOutput("abort_pre_sdo", sdo0, 1'b0);
    checkOutput("abort_pre_busy", busy0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_sdo", sdo0, 1'b1);
    checkOutput("abort_busy", busy0, 1'b0);
    checkOutput("abort_ready", ready0, 1'b0);
    checkOutput("abort_done", done0, 1'b0);
    repeat (2) applyStimulus();
    #2;
    rst = 1'b0;
    applyStimulus();
    checkOutput("abort_rel_ready", ready0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      checkOutput($sformatf("abort_quiet_c%0d_done", c), done0, 1'b0);
      checkOutput($sformatf("abort_quiet_c%0d_sdo", c), sdo0, 1'b1);
      applyStimulus();
    end

    // Fresh frame 8'h5A after the abort
    din0   = 8'h5A;
    valid0 = 1'b1;
    applyStimulus();
    valid0 = 1'b0;
    checkFrameBody(0, 10'b1010110100, 4, "post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_frame_tx.md
Name: ser_frame_tx

Overview:
Parallel-to-serial frame transmitter that sits directly downstream of the universal shift register and consumes its parallel word q.
- Accepts an N-bit word over a valid/ready handshake.
- Emits the word on a single serial line as a framed sequence: one start bit (0), N data bits, one stop bit (1).
- Each bit is held for DIV clock cycles.
- Provides busy and a one-cycle done pulse so upstream control can sequence the next load/shift.

Parameters:
- N, 8, data word width; must be >= 2.
- DIV, 4, clock cycles per serial bit; must be >= 1.
- MSB_FIRST, 0, bit order: 0 = d[0] first, 1 = d[N-1] first.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  N  parallel word to transmit.
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  block can accept a word this cycle.
- sdo  out  1  serial data out; idle level 1.
- busy  out  1  frame in progress (START/DATA/STOP).
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock.
  - While rst=1: state=IDLE, sdo=1, din_ready=0, busy=0, done=0, shift register=0, tick and bit counters=0.
- All outputs are registered; no combinational path from inputs to outputs.
- din_ready:
  - Rises on the first clk edge after rst deasserts.
  - High only in IDLE.
  - Falls on the edge where the handshake occurs.
- Handshake: accept on an edge where din_valid && din_ready.
  - Latch din into the internal shift register.
  - Go to START; busy=1; sdo=0 from that edge.
  - din and din_valid are don't-care at all other times; din_valid while busy is ignored, not queued.
- States:
  - IDLE -> START on handshake.
  - START -> DATA after DIV cycles.
  - DATA -> STOP after N*DIV cycles.
  - STOP -> IDLE after DIV cycles.
- Tick counter: counts 0..DIV-1 in every non-IDLE state and wraps to 0 at each bit boundary. With DIV=1 every cycle is a bit boundary.
- DATA:
  - sdo = current bit (LSB of shift register if MSB_FIRST=0, MSB otherwise).
  - Shift register shifts by one at each bit boundary.
  - Bit counter counts 0..N-1.
- STOP: sdo=1 for DIV cycles.
- Frame timing: the frame occupies exactly (N+2)*DIV cycles starting at the handshake edge.
  - On the edge ending STOP: done=1 for one cycle, busy=0, din_ready=1.
- Back-to-back: the next handshake may occur on the edge after done rises. Minimum inter-frame gap is one idle cycle at sdo=1.
- rst mid-frame: the frame is abandoned immediately (asynchronous); outputs take reset values; no done pulse.
- Counter widths: tick counter $clog2(DIV) bits with a minimum of 1; bit counter $clog2(N) bits. No overflow is possible.

Decomposition:
- Shared package ser_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3.
  - Idle line level constant SER_IDLE=1'b1.
- One sub-module, bit_tick_gen (parameter DIV):
  - Inputs: clk, rst, en.
  - Output: tick, pulsing on the last cycle of each bit period.
  - Counter clears when en=0.
- The FSM, shift register and bit counter live in ser_frame_tx.

Test Plan:
1. Reset, N=8, DIV=4: assert rst mid-cycle -> sdo=1, busy=0, done=0, din_ready=0 immediately; din_ready=1 one edge after release.
2. Single frame, din=8'hA5, MSB_FIRST=0 -> sdo sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done pulses exactly 40 cycles after the handshake edge.
3. MSB_FIRST=1, DIV=1, din=8'hC3 -> sdo 0,1,1,0,0,0,0,1,1,1 on consecutive cycles; done 10 cycles after handshake.
4. Hold din_valid=1 with din changing to 8'hFF during a frame of 8'h00 -> serial data stays all 0; din_ready=0 throughout; no second frame until IDLE.
5. Back-to-back frames 8'h01 then 8'h80 with din_valid held high -> second handshake on the edge after done; exactly one idle cycle at sdo=1 between the frames.
6. Assert rst during the 3rd data bit -> sdo=1 immediately; no done pulse; a new frame after reset transmits correctly.
